// File: rtl/debounce_pkg.sv
// Shared types for the switch debouncer: FSM state encoding.
// Bit 1 of the encoding is the debounced level, so dout follows state[1].
package debounce_pkg;

   typedef enum logic [1:0] {
      LOW       = 2'b00,
      HIGH_PEND = 2'b01,
      HIGH      = 2'b11,
      LOW_PEND  = 2'b10
   } state_e;

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchronizer bringing an asynchronous level into the clk domain.
// Latency SYNC_STAGES edges; no backpressure, samples every edge.
module sync_chain #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [SYNC_STAGES-1:0] sync_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], d};
      end
   end

   assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/debounce_sync.sv
// Synchronizes and debounces a bouncing switch input; emits rise/fall pulses.
// Latency SYNC_STAGES+DEBOUNCE_CYCLES+1 edges from a stable input; no backpressure.
module debounce_sync
   import debounce_pkg::*;
#(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic din_raw,
   output logic dout,
   output logic rise,
   output logic fall,
   output logic pending
);

   localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             s;
   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             dout_q, dout_d;
   logic             rise_q, rise_d;
   logic             fall_q, fall_d;
   logic             pending_q, pending_d;

   sync_chain #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync (
      .clk(clk),
      .rst(rst),
      .d  (din_raw),
      .q  (s)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= LOW;
         cnt_q     <= '0;
         dout_q    <= 1'b0;
         rise_q    <= 1'b0;
         fall_q    <= 1'b0;
         pending_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         dout_q    <= dout_d;
         rise_q    <= rise_d;
         fall_q    <= fall_d;
         pending_q <= pending_d;
      end
   end

   // The entry edge is the first qualifying sample; DEBOUNCE_CYCLES more are needed.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         LOW: begin
            if (s) begin
               state_d = HIGH_PEND;
               cnt_d   = '0;
            end
         end
         HIGH_PEND: begin
            if (!s) begin
               state_d = LOW;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = HIGH;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         HIGH: begin
            if (!s) begin
               state_d = LOW_PEND;
               cnt_d   = '0;
            end
         end
         LOW_PEND: begin
            if (s) begin
               state_d = HIGH;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = LOW;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = LOW;
            cnt_d   = '0;
         end
      endcase
   end

   // Outputs are decoded from the next state so they register alongside it.
   always_comb begin
      dout_d    = (state_d == HIGH) || (state_d == LOW_PEND);
      pending_d = (state_d == HIGH_PEND) || (state_d == LOW_PEND);
      rise_d    = (state_q == HIGH_PEND) && (state_d == HIGH);
      fall_d    = (state_q == LOW_PEND) && (state_d == LOW);
   end

   assign dout    = dout_q;
   assign rise    = rise_q;
   assign fall    = fall_q;
   assign pending = pending_q;

endmodule

// File: tb/tb_debounce_sync.sv
// Bench for debounce_sync: vector table, bounce/reset sequences, random run vs run-length model.
module tb_debounce_sync;

   localparam int S = 2;
   localparam int D = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic din_raw = 1'b0;
   logic dout, rise, fall, pending;

   int checks = 0;
   int errors = 0;

   // Reference model: s is din delayed by S edges; a level change is taken once
   // s has disagreed with the current level for D+1 consecutive edges.
   logic m_sq[$];
   logic m_dout = 1'b0, m_rise = 1'b0, m_fall = 1'b0, m_pend = 1'b0;
   int   m_run = 0;

   always #5 clk = ~clk;

   debounce_sync #(
      .SYNC_STAGES    (S),
      .DEBOUNCE_CYCLES(D)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .din_raw(din_raw),
      .dout   (dout),
      .rise   (rise),
      .fall   (fall),
      .pending(pending)
   );

   task automatic model_edge(input logic r, input logic d);
      logic s;
      if (r) begin
         m_sq.delete();
         for (int k = 0; k < S; k++) m_sq.push_back(1'b0);
         m_dout = 1'b0;
         m_run  = 0;
         m_rise = 1'b0;
         m_fall = 1'b0;
      end else begin
         s = m_sq.pop_front();
         m_sq.push_back(d);
         m_rise = 1'b0;
         m_fall = 1'b0;
         if (s != m_dout) m_run = m_run + 1;
         else             m_run = 0;
         if (m_run == D + 1) begin
            m_dout = s;
            m_rise = s;
            m_fall = ~s;
            m_run  = 0;
         end
      end
      m_pend = (m_run != 0);
   endtask

   task automatic step(input logic r, input logic d);
      rst     = r;
      din_raw = d;
      @(posedge clk);
      model_edge(r, d);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic       r;
      logic       d;
      int         n;
      logic [3:0] exp;   // {dout, rise, fall, pending} after the last edge
      int         rises;
      int         falls;
   } vec_t;

   vec_t tbl[17];

   initial begin
      int nr, nf, rise_at, seg_len;
      logic lvl, r;

      tbl[0]  = '{1'b1, 1'b0, 2,  4'b0000, 0, 0};  // reset, input low
      tbl[1]  = '{1'b0, 1'b1, 2,  4'b0000, 0, 0};  // press: still in synchronizer
      tbl[2]  = '{1'b0, 1'b1, 1,  4'b0001, 0, 0};  // edge 3: pending rises
      tbl[3]  = '{1'b0, 1'b1, 15, 4'b0001, 0, 0};  // edge 18: still pending
      tbl[4]  = '{1'b0, 1'b1, 1,  4'b1100, 1, 0};  // edge 19: accepted
      tbl[5]  = '{1'b0, 1'b1, 1,  4'b1000, 0, 0};  // rise lasts one cycle
      tbl[6]  = '{1'b0, 1'b1, 10, 4'b1000, 0, 0};
      tbl[7]  = '{1'b0, 1'b0, 18, 4'b1001, 0, 0};  // release qualifying
      tbl[8]  = '{1'b0, 1'b0, 1,  4'b0010, 0, 1};  // edge 19: fall
      tbl[9]  = '{1'b0, 1'b0, 1,  4'b0000, 0, 0};
      tbl[10] = '{1'b0, 1'b1, 10, 4'b0001, 0, 0};  // glitch of 10 cycles
      tbl[11] = '{1'b0, 1'b0, 2,  4'b0001, 0, 0};  // still draining the chain
      tbl[12] = '{1'b0, 1'b0, 1,  4'b0000, 0, 0};  // aborted, no rise
      tbl[13] = '{1'b0, 1'b1, 10, 4'b0001, 0, 0};  // 8 edges into HIGH_PEND
      tbl[14] = '{1'b1, 1'b1, 1,  4'b0000, 0, 0};  // reset aborts
      tbl[15] = '{1'b0, 1'b1, 18, 4'b0001, 0, 0};
      tbl[16] = '{1'b0, 1'b1, 1,  4'b1100, 1, 0};  // full latency after release

      for (int i = 0; i < 17; i++) begin
         nr = 0;
         nf = 0;
         for (int c = 0; c < tbl[i].n; c++) begin
            step(tbl[i].r, tbl[i].d);
            nr += int'(rise);
            nf += int'(fall);
         end
         chk($sformatf("vec%0d_outs", i), {28'd0, dout, rise, fall, pending}, {28'd0, tbl[i].exp});
         chk($sformatf("vec%0d_rises", i), nr, tbl[i].rises);
         chk($sformatf("vec%0d_falls", i), nf, tbl[i].falls);
      end

      // Return low, then a bouncy press: 3 high, 5 low, 2 high, 3 low, hold high.
      nf = 0;
      for (int c = 0; c < 25; c++) begin
         step(1'b0, 1'b0);
         nf += int'(fall);
      end
      chk("bounce_pre_dout", dout, 1'b0);
      chk("bounce_pre_falls", nf, 1);
      nr = 0;
      for (int c = 0; c < 3; c++) begin step(1'b0, 1'b1); nr += int'(rise); end
      for (int c = 0; c < 5; c++) begin step(1'b0, 1'b0); nr += int'(rise); end
      for (int c = 0; c < 2; c++) begin step(1'b0, 1'b1); nr += int'(rise); end
      for (int c = 0; c < 3; c++) begin step(1'b0, 1'b0); nr += int'(rise); end
      rise_at = -1;
      for (int c = 1; c <= 30; c++) begin
         step(1'b0, 1'b1);
         if (rise) begin
            nr++;
            if (rise_at < 0) rise_at = c;
         end
      end
      chk("bounce_rise_edge", rise_at, S + D + 1);
      chk("bounce_rise_count", nr, 1);
      chk("bounce_dout", dout, 1'b1);

      // Random segments against the model, with occasional resets.
      for (int seg = 0; seg < 300; seg++) begin
         lvl     = 1'($urandom_range(0, 1));
         seg_len = (($urandom_range(0, 3) == 0) ? $urandom_range(18, 30) : $urandom_range(1, 20));
         r       = ($urandom_range(0, 39) == 0);
         for (int c = 0; c < seg_len; c++) begin
            step((c == 0) ? r : 1'b0, lvl);
            chk("rand_outs", {28'd0, dout, rise, fall, pending},
                {28'd0, m_dout, m_rise, m_fall, m_pend});
            chk("rand_rise_fall_excl", rise & fall, 1'b0);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
